muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide unit; define MULDIV_DIV_EN to build in the divider
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  funct3,
  input  logic [31:0] src_data0,
  input  logic [31:0] src_data1,
  input  logic [4:0]  dst_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_we,
  output logic [4:0]  out_dst_addr,
  output logic [31:0] out_data,
  output logic        out_illegal
);
`ifdef MULDIV_DIV_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`endif
  state_t state;
  logic setup, neg, sa, sb;
  logic [4:0] cnt;
  logic [2:0] f;
  logic [63:0] x, acc, prod, mres;
  logic [31:0] y, ma, mb, mul_out;
  assign in_ready = state == IDLE;
  // operand signs/magnitudes and one shift-add multiply step with final sign fix
  always_comb begin
    sa = x[31] & (f == 3'd1 | f == 3'd2 | f == 3'd4 | f == 3'd6);
    sb = y[31] & (f == 3'd1 | f == 3'd4 | f == 3'd6);
    ma = sa ? -x[31:0] : x[31:0];
    mb = sb ? -y : y;
    prod = acc + (y[0] ? x : 64'd0);
    mres = neg ? -prod : prod;
    mul_out = f == 3'd0 ? mres[31:0] : mres[63:32];
  end
`ifdef MULDIV_DIV_EN
  logic neg_r, ge, ovf;
  logic [32:0] t, d;
  logic [31:0] q, r, div_out;
  // one restoring-division step on {remainder, dividend/quotient} held in acc
  always_comb begin
    ovf = (f == 3'd4 | f == 3'd6) & x[31:0] == 32'h8000_0000 & y == 32'hFFFF_FFFF;
    t = {acc[63:32], acc[31]};
    d = t - {1'b0, x[31:0]};
    ge = t >= {1'b0, x[31:0]};
    r = ge ? d[31:0] : t[31:0];
    q = {acc[30:0], ge};
    div_out = f[1] ? (neg_r ? -r : r) : (neg ? -q : q);
  end
`endif
  // control FSM with registered result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      setup <= 1'b0;
      cnt <= 5'd0;
      f <= 3'd0;
      x <= 64'd0;
      y <= 32'd0;
      acc <= 64'd0;
      neg <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_r <= 1'b0;
`endif
      out_valid <= 1'b0;
      out_we <= 1'b0;
      out_dst_addr <= 5'd0;
      out_data <= 32'd0;
      out_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          f <= funct3;
          x <= {32'd0, src_data0};
          y <= src_data1;
          out_dst_addr <= dst_addr;
          setup <= 1'b1;
          cnt <= 5'd0;
`ifdef MULDIV_DIV_EN
          state <= funct3[2] ? DIV : MUL;
`else
          state <= MUL;
`endif
        end
        MUL: if (setup) begin
          setup <= 1'b0;
          x <= {32'd0, ma};
          y <= mb;
          acc <= 64'd0;
          neg <= sa ^ sb;
`ifndef MULDIV_DIV_EN
          if (f[2]) begin
            state <= DONE;
            out_valid <= 1'b1;
            out_data <= 32'd0;
            out_illegal <= 1'b1;
            out_we <= 1'b0;
          end
`endif
        end else begin
          cnt <= cnt + 5'd1;
          acc <= prod;
          x <= x << 1;
          y <= y >> 1;
          if (cnt == 5'd31) begin
            state <= DONE;
            out_valid <= 1'b1;
            out_data <= mul_out;
            out_illegal <= 1'b0;
            out_we <= out_dst_addr != 5'd0;
          end
        end
`ifdef MULDIV_DIV_EN
        DIV: if (setup) begin
          if (y == 32'd0 || ovf) begin
            state <= DONE;
            out_valid <= 1'b1;
            out_illegal <= 1'b0;
            out_we <= out_dst_addr != 5'd0;
            out_data <= y == 32'd0 ? (f[1] ? x[31:0] : 32'hFFFF_FFFF) : (f[1] ? 32'd0 : 32'h8000_0000);
          end else begin
            setup <= 1'b0;
            x <= {32'd0, mb};
            acc <= {32'd0, ma};
            neg <= sa ^ sb;
            neg_r <= sa;
          end
        end else begin
          cnt <= cnt + 5'd1;
          acc <= {r, q};
          if (cnt == 5'd31) begin
            state <= DONE;
            out_valid <= 1'b1;
            out_data <= div_out;
            out_illegal <= 1'b0;
            out_we <= out_dst_addr != 5'd0;
          end
        end
`endif
        DONE: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
          out_we <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
